// File: rtl/bcd_share_arb_if.sv
// Bundle between the game counters, the shared-converter arbiter and the binary-to-BCD converter.
// slave = arbiter view, master = requester/converter side.
interface bcd_share_arb_if #(
    parameter int NREQ = 3
);
    logic [NREQ-1:0]   req;
    logic [NREQ*8-1:0] bin_in;
    logic [NREQ-1:0]   gnt;
    logic              valid;
    logic [11:0]       bcd_out;
    logic              err;
    logic              conv_start;
    logic [7:0]        conv_bin;
    logic              conv_done;
    logic [11:0]       conv_bcd;

    modport slave (
        input  req, bin_in, conv_done, conv_bcd,
        output gnt, valid, bcd_out, err, conv_start, conv_bin
    );

    modport master (
        output req, bin_in, conv_done, conv_bcd,
        input  gnt, valid, bcd_out, err, conv_start, conv_bin
    );
endinterface

// File: rtl/bcd_share_arb.sv
// Round-robin sharing of one binary-to-BCD converter among NREQ display counters,
// with a timeout that returns err=1 and zero digits if the converter stalls.
module bcd_share_arb #(
    parameter int NREQ    = 3,
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    bcd_share_arb_if.slave   bus
);
    localparam int IW = $clog2(NREQ);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, START, WAIT, RESP} state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [7:0]      bin_q, bin_d;
    logic [11:0]     bcd_q, bcd_d;
    logic            err_q, err_d;
    logic [TW-1:0]   timer_q, timer_d;

    logic [NREQ-1:0][7:0] bin_arr;
    logic                 found;
    logic [IW-1:0]        win;
    logic [NREQ-1:0]      gnt;
    logic                 valid;
    logic                 conv_start;

    assign bin_arr = bus.bin_in;

    // Search starts one past the last winner, so the last-served requester ranks lowest.
    always_comb begin
        int j;
        found = 1'b0;
        win   = '0;
        j     = 0;
        for (int off = 1; off <= NREQ; off++) begin
            j = int'(ptr_q) + off;
            if (j >= NREQ) j = j - NREQ;
            if (!found && bus.req[IW'(j)]) begin
                found = 1'b1;
                win   = IW'(j);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= IW'(NREQ - 1);
            idx_q   <= '0;
            bin_q   <= '0;
            bcd_q   <= '0;
            err_q   <= 1'b0;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            err_q   <= err_d;
            timer_q <= timer_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        bin_d   = bin_q;
        bcd_d   = bcd_q;
        err_d   = err_q;
        timer_d = timer_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    idx_d   = win;
                    bin_d   = bin_arr[win];
                    state_d = START;
                end
            end
            START: begin
                timer_d = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (bus.conv_done) begin
                    bcd_d   = bus.conv_bcd;
                    err_d   = 1'b0;
                    state_d = RESP;
                end else if (timer_q == TW'(TIMEOUT - 1)) begin
                    bcd_d   = '0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            RESP: begin
                ptr_d   = idx_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        gnt        = '0;
        valid      = 1'b0;
        conv_start = 1'b0;
        case (state_q)
            START: conv_start = 1'b1;
            RESP: begin
                valid      = 1'b1;
                gnt[idx_q] = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.gnt        = gnt;
    assign bus.valid      = valid;
    assign bus.conv_start = conv_start;
    assign bus.conv_bin   = bin_q;
    assign bus.bcd_out    = bcd_q;
    assign bus.err        = err_q;
endmodule

// File: doc/bcd_share_arb.md
Name: bcd_share_arb

Overview:
- Round-robin arbiter and sequencer that shares one 8-bit binary-to-BCD converter among several requesters: score, combo counter and countdown timer of the piano-block game.
- Each requester posts a binary value and receives the hundreds/tens/ones digits for the 7-segment display driver.
- Sits between the game-logic counters and the shared converter; drives the converter's start/done handshake and recovers from a stalled converter with a timeout.

Parameters:
- NREQ, 3, number of requesters (2..8).
- TIMEOUT, 16, max WAIT cycles for conv_done before abort (converter nominally needs 9–10).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- req  in  NREQ  level request per requester; held high until its gnt pulse.
- bin_in  in  NREQ*8  packed values; requester i uses bits [8i+7:8i].
- gnt  out  NREQ  one-hot, one-cycle pulse: result for requester i is valid.
- valid  out  1  high in the same cycle as any gnt bit.
- bcd_out  out  12  {hun,ten,one} result, valid with gnt.
- err  out  1  high with gnt when the conversion timed out.
- conv_start  out  1  one-cycle start pulse to the converter.
- conv_bin  out  8  operand to the converter, stable from START until WAIT exits.
- conv_done  in  1  converter result strobe.
- conv_bcd  in  12  converter result {hun,ten,one}, sampled when conv_done=1.

Behaviour:
- Reset values: state=IDLE, ptr=NREQ-1, gnt=0, valid=0, err=0, bcd_out=0, conv_start=0, conv_bin=0, timer=0. Reset is asynchronous at any point, including mid-WAIT, and abandons any conversion in flight. The converter's own reset is separate.
- FSM states: IDLE, START, WAIT, RESP.
- IDLE:
  - If req is nonzero, pick the winner by round-robin: search indices ptr+1, ptr+2, … modulo NREQ and take the first one with req set.
  - Latch the winner's index into idx and its bin_in slice into conv_bin.
  - Next state is START.
  - If req is zero, stay in IDLE.
- START:
  - conv_start=1 for exactly this cycle; timer cleared.
  - conv_done in this cycle is ignored.
  - Next state is WAIT.
- WAIT:
  - If conv_done=1: capture conv_bcd into bcd_out, set err=0, go to RESP.
  - Else if timer==TIMEOUT-1: set bcd_out=12'h000 and err=1, go to RESP.
  - Else increment timer.
- RESP:
  - gnt[idx]=1 and valid=1 for one cycle; ptr updated to idx.
  - Next state is IDLE.
  - bcd_out and err hold their values until the next RESP.
- Latency: from req seen in IDLE (cycle 0), conv_start is at cycle 1. If conv_done arrives k cycles after START, gnt fires k+1 cycles after START.
- Only one conversion is outstanding at a time; new requests wait in IDLE.
- A requester that drops req after being latched does not cancel its conversion; it still receives gnt.
- A req still high in the IDLE cycle after its gnt is treated as a new request. Round-robin gives the other pending requesters priority first.
- conv_bin is not re-sampled from bin_in during START or WAIT, so later changes to bin_in have no effect on the current conversion.
- Out-of-range digits from the converter (>9) are passed through unchanged; no checking is done.
- A conv_done seen in IDLE or RESP is ignored.

Test Plan:
- Single requester: req[0]=1, bin_in[7:0]=8'd173, converter model done 9 cycles after start → gnt=3'b001 at cycle 11, bcd_out=12'h173, err=0, one conv_start pulse.
- All three requesters asserted from reset, with values 8'd5, 8'd99, 8'd255 → grants in order 0,1,2, with bcd_out 12'h005, 12'h099, 12'h255 respectively. Exactly three conv_start pulses, each followed by its gnt before the next start.
- Fairness: req[0] held high permanently, req[2] raised mid-conversion of requester 0 → the next grant goes to requester 2 before requester 0 again.
- Timeout: converter model never asserts conv_done → gnt exactly TIMEOUT+1 cycles after conv_start, with err=1 and bcd_out=12'h000. A subsequent normal request completes with err=0.
- Reset mid-WAIT: rst_n pulled low 4 cycles after conv_start → all outputs zero immediately. After release, a new req[1] is granted normally and ptr has restarted at NREQ-1.
- Spurious conv_done in IDLE, and bin_in changed during WAIT → no gnt is produced by the spurious strobe, and the result reflects the operand latched at grant.
